// File: rtl/memory_arbiter_if.sv
// Load/store request bus: a requester-side handshake that is the same shape as
// the single-ported data memory's own Read/Write/busywait interface.
interface memory_arbiter_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        busywait;

  modport master (
    output read, write, address, write_data, func3,
    input  read_data, busywait
  );

  modport slave (
    input  read, write, address, write_data, func3,
    output read_data, busywait
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-ported data
// memory; per-port busywait mimics the memory's own, with a sticky WAIT timeout.
module memory_arbiter #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  memory_arbiter_if.slave  p0_if,
  memory_arbiter_if.slave  p1_if,
  memory_arbiter_if.master mem_if,
  output logic             error_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and latch the winner's request
  // ISSUE | one-cycle Mem_Read/Mem_Write pulse from the latched op
  // WAIT  | count cycles until memory drops busywait or WAIT_LIMIT is hit
  // DONE  | granted port's busywait low for one cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        op_wr_q, op_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  func3_q, func3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        error_q, error_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        req0;
  logic        req1;
  logic [7:0]  cnt_inc;

  assign req0    = p0_if.read | p0_if.write;
  assign req1    = p1_if.read | p1_if.write;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    logic        grant_sel;
    logic [31:0] load_val;
    grant_sel    = 1'b0;
    load_val     = '0;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    func3_d      = func3_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          // On a tie the port that was not served last wins.
          grant_sel = (req0 & req1) ? ~last_grant_q : req1;
          grant_d   = grant_sel;
          op_wr_d   = grant_sel ? p1_if.write      : p0_if.write;
          addr_d    = grant_sel ? p1_if.address    : p0_if.address;
          wdata_d   = grant_sel ? p1_if.write_data : p0_if.write_data;
          func3_d   = grant_sel ? p1_if.func3      : p0_if.func3;
          cnt_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mem_if.busywait || (cnt_inc == 8'(WAIT_LIMIT))) begin
          state_d      = ST_DONE;
          last_grant_d = grant_q;
          if (mem_if.busywait) begin
            error_d = 1'b1;
          end
          if (!op_wr_q) begin
            load_val = mem_if.busywait ? 32'd0 : mem_if.read_data;
            if (grant_q) begin
              rdata1_d = load_val;
            end else begin
              rdata0_d = load_val;
            end
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      func3_q      <= '0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      func3_q      <= func3_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Pulses decode from state so reset removes them without waiting for a clock.
  assign mem_if.read       = (state_q == ST_ISSUE) & ~op_wr_q;
  assign mem_if.write      = (state_q == ST_ISSUE) &  op_wr_q;
  assign mem_if.address    = addr_q;
  assign mem_if.write_data = wdata_q;
  assign mem_if.func3      = func3_q;

  assign p0_if.busywait  = req0 & ~((state_q == ST_DONE) & (grant_q == 1'b0));
  assign p1_if.busywait  = req1 & ~((state_q == ST_DONE) & (grant_q == 1'b1));
  assign p0_if.read_data = rdata0_q;
  assign p1_if.read_data = rdata1_q;

  assign error_o = error_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: byte-addressed memory model with a
// one-wait busywait handshake and a stuck mode for the timeout path.
module tb_memory_arbiter;

  logic clk;
  logic rst_n;
  logic error;
  logic stuck;

  memory_arbiter_if p0_bus ();
  memory_arbiter_if p1_bus ();
  memory_arbiter_if mem_bus ();

  memory_arbiter #(.WAIT_LIMIT(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .p0_if   (p0_bus),
    .p1_if   (p1_bus),
    .mem_if  (mem_bus),
    .error_o (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [7:0]  mem_arr [0:255];
  logic        mem_init_done = 1'b0;
  logic        m_busy, m_pend, m_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_f3;

  function automatic logic [31:0] mem_load(input logic [7:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = {mem_arr[8'(a + 8'd3)], mem_arr[8'(a + 8'd2)], mem_arr[8'(a + 8'd1)], mem_arr[a]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_pend <= 1'b0;
      if (!mem_init_done) begin
        for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
        mem_arr[8'h10] <= 8'hEF;
        mem_arr[8'h11] <= 8'hBE;
        mem_arr[8'h12] <= 8'hAD;
        mem_arr[8'h13] <= 8'hDE;
        mem_init_done  <= 1'b1;
      end
    end else if (m_pend) begin
      if (!stuck) begin
        if (m_wr) begin
          mem_arr[m_addr[7:0]] <= m_wdata[7:0];
          if (m_f3[1:0] != 2'b00) mem_arr[8'(m_addr[7:0] + 8'd1)] <= m_wdata[15:8];
          if (m_f3[1:0] == 2'b10) begin
            mem_arr[8'(m_addr[7:0] + 8'd2)] <= m_wdata[23:16];
            mem_arr[8'(m_addr[7:0] + 8'd3)] <= m_wdata[31:24];
          end
        end else begin
          m_rdata <= mem_load(m_addr[7:0], m_f3);
        end
        m_busy <= 1'b0;
        m_pend <= 1'b0;
      end
    end else if (mem_bus.read | mem_bus.write) begin
      m_pend  <= 1'b1;
      m_busy  <= 1'b1;
      m_wr    <= mem_bus.write;
      m_addr  <= mem_bus.address;
      m_wdata <= mem_bus.write_data;
      m_f3    <= mem_bus.func3;
    end
  end

  assign mem_bus.busywait  = m_busy;
  assign mem_bus.read_data = m_rdata;

  // ---------------- monitors ----------------
  int grant_log[$];
  int rd_pulses = 0;
  int wr_pulses = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ((p0_bus.read | p0_bus.write) & ~p0_bus.busywait) grant_log.push_back(0);
      if ((p1_bus.read | p1_bus.write) & ~p1_bus.busywait) grant_log.push_back(1);
      if (mem_bus.read)  rd_pulses++;
      if (mem_bus.write) wr_pulses++;
    end
  end

  // ---------------- requester helpers ----------------
  task automatic set_req(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    if (port == 0) begin
      p0_bus.read = rd; p0_bus.write = wr; p0_bus.address = addr;
      p0_bus.write_data = wdata; p0_bus.func3 = f3;
    end else begin
      p1_bus.read = rd; p1_bus.write = wr; p1_bus.address = addr;
      p1_bus.write_data = wdata; p1_bus.func3 = f3;
    end
  endtask

  function automatic logic get_bw(input int port);
    return (port == 0) ? p0_bus.busywait : p1_bus.busywait;
  endfunction

  function automatic logic [31:0] get_rd(input int port);
    return (port == 0) ? p0_bus.read_data : p1_bus.read_data;
  endfunction

  // Called just after a rising edge; returns just after the edge leaving DONE.
  // lat counts the falling edges at which the requester saw busywait high.
  task automatic port_xact(input int port, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] f3,
                           output logic [31:0] rdata, output int lat);
    int guard;
    lat = 0;
    guard = 0;
    set_req(port, ~wr, wr, addr, wdata, f3);
    @(negedge clk);
    while (get_bw(port) && guard < 200) begin
      lat++;
      guard++;
      @(negedge clk);
    end
    check_val("handshake_within_bound", 32'(guard < 200), 32'd1);
    @(posedge clk);
    #1;
    set_req(port, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    rdata = get_rd(port);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [31:0] r0, r1;
  int          l0, l1, guard, n;

  initial begin
    rst_n = 1'b0;
    stuck = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Reset values
    #12;
    check_val("rst_mem_read",   mem_bus.read, 1'b0);
    check_val("rst_mem_write",  mem_bus.write, 1'b0);
    check_val("rst_error",      error, 1'b0);
    check_val("rst_mem_addr",   mem_bus.address, 32'd0);
    check_val("rst_p0_rdata",   p0_bus.read_data, 32'd0);
    check_val("rst_p0_bw_idle", p0_bus.busywait, 1'b0);
    p0_bus.read = 1'b1;
    #1;
    check_val("rst_p0_bw_req",  p0_bus.busywait, 1'b1);
    p0_bus.read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single load on port 0
    rd_pulses = 0;
    wr_pulses = 0;
    port_xact(0, 1'b0, 32'h10, 32'd0, 3'b010, r0, l0);
    check_val("ld0_data",      r0, 32'hDEADBEEF);
    check_val("ld0_latency",   l0, 32'd4);
    check_val("ld0_rd_pulses", rd_pulses, 32'd1);
    check_val("ld0_wr_pulses", wr_pulses, 32'd0);

    // Simultaneous requests after reset: port 0 wins the first tie
    do_reset();
    grant_log.delete();
    fork
      port_xact(0, 1'b1, 32'h20, 32'h11223344, 3'b010, r0, l0);
      port_xact(1, 1'b0, 32'h20, 32'd0,        3'b010, r1, l1);
    join
    check_val("sim_p1_data",   r1, 32'h11223344);
    check_val("sim_p0_lat",    l0, 32'd4);
    check_val("sim_p1_lat",    l1, 32'd9);
    check_val("sim_log_size",  grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check_val("sim_first",  grant_log[0], 32'd0);
      check_val("sim_second", grant_log[1], 32'd1);
    end

    // Fairness: both ports requesting continuously, 8 transactions.
    // Worst wait = own 5-cycle slot behind one other 5-cycle slot, minus DONE.
    grant_log.delete();
    fork
      begin
        logic [31:0] rd;
        int lt;
        for (int i = 0; i < 4; i++) begin
          port_xact(0, 1'b1, 32'h40 + 32'(i * 4), 32'(i + 1), 3'b010, rd, lt);
          check_val("fair_p0_lat_le9", 32'(lt <= 9), 32'd1);
        end
      end
      begin
        logic [31:0] rd;
        int lt;
        for (int j = 0; j < 4; j++) begin
          port_xact(1, 1'b0, 32'h20, 32'd0, 3'b010, rd, lt);
          check_val("fair_p1_data", rd, 32'h11223344);
          check_val("fair_p1_lat_le9", 32'(lt <= 9), 32'd1);
        end
      end
    join
    check_val("fair_log_size", grant_log.size(), 32'd8);
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      check_val("fair_order", grant_log[k], 32'(k % 2));
    port_xact(0, 1'b0, 32'h4C, 32'd0, 3'b010, r0, l0);
    check_val("fair_readback", r0, 32'd4);

    // Byte store / signed and unsigned byte loads on port 1
    port_xact(1, 1'b1, 32'h3, 32'h123456A5, 3'b000, r1, l1);
    check_val("sb_keeps_rdata", r1, 32'h11223344);
    port_xact(1, 1'b0, 32'h3, 32'd0, 3'b000, r1, l1);
    check_val("lb_data", r1, 32'hFFFFFFA5);
    port_xact(1, 1'b0, 32'h3, 32'd0, 3'b100, r1, l1);
    check_val("lbu_data", r1, 32'h000000A5);
    port_xact(1, 1'b0, 32'h0, 32'd0, 3'b010, r1, l1);
    check_val("sb_only_one_byte", r1, 32'hA5000000);
    check_val("pre_to_error", error, 1'b0);

    // Timeout: memory never releases busywait
    stuck = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_bus.read && guard < 20);
    check_val("to_issue_seen", mem_bus.read, 1'b1);
    n = 0;
    @(negedge clk);
    while (!error && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val("to_wait_cycles", n, 32'd16);
    check_val("to_p0_bw_low",   p0_bus.busywait, 1'b0);
    check_val("to_p0_rdata",    p0_bus.read_data, 32'd0);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    stuck = 1'b0;
    port_xact(0, 1'b0, 32'h10, 32'd0, 3'b010, r0, l0);
    check_val("post_to_data",   r0, 32'hDEADBEEF);
    check_val("post_to_lat",    l0, 32'd4);
    check_val("post_to_sticky", error, 1'b1);

    // Reset during ISSUE clears the pulse asynchronously
    set_req(0, 1'b1, 1'b0, 32'h10, 32'd0, 3'b010);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_bus.read && guard < 20);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_issue_mem_read", mem_bus.read, 1'b0);
    check_val("rst_issue_error",    error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    @(negedge clk);
    while (p0_bus.busywait && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check_val("rst_issue_reserved", p0_bus.read_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    // Reset during WAIT
    set_req(1, 1'b1, 1'b0, 32'h20, 32'd0, 3'b010);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mem_bus.read && guard < 20);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_wait_mem_read",  mem_bus.read, 1'b0);
    check_val("rst_wait_mem_write", mem_bus.write, 1'b0);
    check_val("rst_wait_addr",      mem_bus.address, 32'd0);
    check_val("rst_wait_wdata",     mem_bus.write_data, 32'd0);
    check_val("rst_wait_func3",     mem_bus.func3, 32'd0);
    check_val("rst_wait_p0_rdata",  p0_bus.read_data, 32'd0);
    check_val("rst_wait_p1_rdata",  p1_bus.read_data, 32'd0);
    check_val("rst_wait_p1_bw",     p1_bus.busywait, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    @(negedge clk);
    while (p1_bus.busywait && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check_val("rst_wait_reserved", p1_bus.read_data, 32'h11223344);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It accepts load/store requests from two requesters: port 0 is the MEM-stage load/store unit, and port 1 is the secondary master (program loader / debug). It grants one request at a time with round-robin fairness and drives the memory's one-cycle Read/Write pulse handshake. It returns data and a per-port busywait that is a drop-in replacement for the memory's own busywait, and it flags a memory that never completes.

## Interface
- WAIT_LIMIT, 16: maximum cycles in WAIT before timeout; legal range 2..255.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- P0_Read, P0_Write  in  1 each  port 0 request; held until P0_busywait is low.
- P0_Address  in  32  port 0 byte address.
- P0_Write_data  in  32  port 0 store data.
- P0_Func3  in  3  port 0 access size/sign.
- P0_Read_data  out  32  port 0 load result, registered.
- P0_busywait  out  1  port 0 stall.
- P1_Read, P1_Write, P1_Address, P1_Write_data, P1_Func3, P1_Read_data, P1_busywait: same as the port 0 signals, for port 1.
- Mem_Read, Mem_Write  out  1 each  pulses to memory.
- Mem_Address  out  32  address to memory.
- Mem_Write_data  out  32  store data to memory.
- Mem_Func3  out  3  access size/sign to memory.
- Mem_Read_data  in  32  memory load data.
- Mem_busywait  in  1  memory stall.
- Error  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- **IDLE:**
  - If any port has a request (Read|Write), grant one port and go to ISSUE.
  - When the grant is made, latch the granted port's op, Address, Write_data and Func3 into internal registers.
  - If a port asserts both Read and Write, the request is treated as a write.
- **Arbitration:** round-robin.
  - A 1-bit last_grant register records the port served most recently; it is 1 after reset, so port 0 wins the first tie.
  - When both ports request, the grant goes to the port that is not last_grant. When only one port requests, that port is granted.
  - last_grant updates on entry to DONE.
- **ISSUE:** lasts exactly one cycle.
  - Mem_Read or Mem_Write is high, per the latched op.
  - Mem_Address, Mem_Write_data and Mem_Func3 are driven from the latched registers in every state, so they stay stable throughout the transaction.
  - Next state is WAIT unconditionally.
- **WAIT:**
  - Mem_Read and Mem_Write are low.
  - Each cycle, a wait counter increments from 0.
  - If Mem_busywait is sampled low, go to DONE. For a read, Mem_Read_data is captured into the granted port's Read_data register on that same edge.
  - If the counter reaches WAIT_LIMIT first, go to DONE with Error set. For a read, the granted port's Read_data is loaded with 0.
- **DONE:** lasts one cycle.
  - The granted port's busywait is low, which completes its handshake.
  - Next state is IDLE.
- **Requester busywait:** Px_busywait = (Px_Read|Px_Write) & ~(state==DONE & grant==x). It is combinational, so a new request stalls its requester in the same cycle it appears.
- **Read data:** Px_Read_data changes only on completion of a read by port x. Writes leave it unchanged.
- **Error:** once set, it stays set until reset; it does not block further transactions.
- **Request changes:** a port that drops or changes its request while it is not granted has no effect. A granted transaction always runs to DONE using the latched values.

## Timing
- **Reset values:**
  - State is IDLE; last_grant is 1.
  - Mem_Read, Mem_Write and Error are 0.
  - Mem_Address, Mem_Write_data, Mem_Func3, P0_Read_data and P1_Read_data are 0.
  - Px_busywait follows its combinational formula (1 if a request is present).
- **Uncontended transaction with a single-wait memory:**
  - Request sampled at edge t, entering ISSUE.
  - Memory sees Mem_Read/Mem_Write at edge t+1, entering WAIT.
  - Mem_busywait is 1 at edge t+2; data returns and Mem_busywait falls during the cycle after t+2.
  - Mem_busywait is sampled low at edge t+3, entering DONE.
  - Back to IDLE at t+4.
  - Px_busywait is low during cycle t+3..t+4.
- Throughput is one transaction per 4 cycles minimum. Back-to-back requests from alternating ports each wait at most one extra transaction.
- **Timeout boundary:** Error rises on the edge where the counter equals WAIT_LIMIT, and the FSM leaves WAIT on that same edge.
- **Reset mid-transaction:** Reset_n low in any state forces IDLE immediately and clears Mem_Read/Mem_Write asynchronously. The in-flight request is dropped; a requester still asserting is re-arbitrated after reset.

## Test plan
- **Single load, port 0:** P0_Read with Address 0x10, Func3 010, memory word 0xDEADBEEF → one-cycle Mem_Read pulse; P0_busywait low for exactly one cycle, 4 cycles after the request; P0_Read_data = 0xDEADBEEF.
- **Simultaneous requests after reset:** P0 SW 0x11223344 @0x20 and P1 LW @0x20 asserted in the same cycle → port 0 is served first, then port 1, which reads 0x11223344.
- **Fairness under load:** both ports requesting continuously for 8 transactions → grants alternate 0,1,0,1…; no port waits longer than one other transaction.
- **Byte store/load through latched Func3:** P1 SB 0xA5 @0x3, then LB @0x3 → P1_Read_data = 0xFFFFFFA5; after LBU, P1_Read_data = 0x000000A5.
- **Timeout:** memory model holds Mem_busywait high; WAIT_LIMIT=16 → Error rises 16 cycles after entering WAIT; Px_Read_data = 0; the next transaction completes normally with Error still 1.
- **Reset mid-WAIT:** Reset_n pulsed low during WAIT → state IDLE, all outputs at reset values within the same cycle; the held request is re-served after reset.
